apb_reg_slave: RTL and testbench



---
 rtl/apb_reg_slave.sv | 139 +++++++++++++
 tb/tb_apb_reg_slave.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/apb_reg_slave.sv
// APB register bank: NUM_REGS read/write words plus a read-only transfer counter,
// with a fixed number of access-phase wait states and an error response for bad accesses.
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | no transfer in its access phase
// ACCESS | access phase running, counting wait states

module apb_reg_slave #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NUM_REGS       = 8,
    parameter int WAIT_CYCLES    = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
    input  logic [31:0]               pwdata_i,
    input  logic                      pwrite_i,
    input  logic                      psel_i,
    input  logic                      penable_i,
    output logic [31:0]               prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o,
    output logic [32*NUM_REGS-1:0]    regs_o
);

    localparam int IDX_W = APB_ADDR_WIDTH - 2;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        wcnt;
    logic [31:0]       xfer_cnt;
    logic [31:0]       regs [NUM_REGS];

    logic [IDX_W-1:0]  idx;
    logic              is_reg;
    logic              is_cnt;
    logic              misaligned;
    logic              bad_access;
    logic              access;
    logic              ready;
    logic [31:0]       rd_word;

    assign idx        = paddr_i[APB_ADDR_WIDTH-1:2];
    assign is_reg     = idx < IDX_W'(NUM_REGS);
    assign is_cnt     = idx == IDX_W'(NUM_REGS);
    assign misaligned = |paddr_i[1:0];
    assign bad_access = misaligned | (!is_reg & !is_cnt) | (pwrite_i & is_cnt);
    assign access     = psel_i & penable_i;

    // Gated by rst_i so the handshake drops the moment reset is asserted.
    assign ready      = !rst_i & access & (wcnt == 4'(WAIT_CYCLES));

    assign pready_o   = ready;
    assign pslverr_o  = ready & bad_access;

    always_comb begin
        rd_word = '0;
        if (is_cnt) begin
            rd_word = xfer_cnt;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (idx == IDX_W'(k)) begin
                    rd_word = regs[k];
                end
            end
        end
    end

    assign prdata_o = (ready & !pwrite_i & !bad_access) ? rd_word : 32'h0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (access & !ready) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (ready | !psel_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // An aborted access (psel dropped early) clears the count so the next one waits in full.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wcnt <= '0;
        end else if (ready | !psel_i) begin
            wcnt <= '0;
        end else if (access) begin
            wcnt <= wcnt + 4'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            xfer_cnt <= '0;
        end else if (ready) begin
            xfer_cnt <= xfer_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= '0;
            end
        end else if (ready & pwrite_i & !bad_access) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (idx == IDX_W'(k)) begin
                    regs[k] <= pwdata_i;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_o[32*g +: 32] = regs[g];
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Bench for apb_reg_slave: a 2-wait-state instance and a zero-wait instance share the
// APB bus (separate selects); expected responses are queued per transfer and checked on pready.

module tb_apb_reg_slave;

    logic         clk = 1'b0;
    logic         rst;
    logic [11:0]  paddr;
    logic [31:0]  pwdata;
    logic         pwrite;
    logic         psel;
    logic         psel0;
    logic         penable;

    logic [31:0]  prdata,  prdata0;
    logic         pready,  pready0;
    logic         pslverr, pslverr0;
    logic [255:0] regs_w,  regs_w0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          waits;
    } exp_t;

    exp_t        sb_q [$];
    logic [31:0] exp_regs [8];
    logic [31:0] exp_cnt;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    apb_reg_slave #(.APB_ADDR_WIDTH(12), .NUM_REGS(8), .WAIT_CYCLES(2)) dut (
        .clk_i(clk), .rst_i(rst), .paddr_i(paddr), .pwdata_i(pwdata), .pwrite_i(pwrite),
        .psel_i(psel), .penable_i(penable), .prdata_o(prdata), .pready_o(pready),
        .pslverr_o(pslverr), .regs_o(regs_w)
    );

    apb_reg_slave #(.APB_ADDR_WIDTH(12), .NUM_REGS(8), .WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .paddr_i(paddr), .pwdata_i(pwdata), .pwrite_i(pwrite),
        .psel_i(psel0), .penable_i(penable), .prdata_o(prdata0), .pready_o(pready0),
        .pslverr_o(pslverr0), .regs_o(regs_w0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One transfer; which=1 targets the zero-wait instance. Leaves the bus in the
    // completing access cycle so a following call starts its setup back-to-back.
    task automatic xfer(input bit which, input logic [11:0] addr, input logic wr,
                        input logic [31:0] wd, input logic exp_err,
                        input logic [31:0] exp_rd, input int exp_waits);
        exp_t e;
        exp_t got;
        int   n;
        bit   rdy;
        e.err = exp_err; e.rdata = exp_rd; e.waits = exp_waits;
        sb_q.push_back(e);
        @(posedge clk); #1;
        paddr = addr; pwrite = wr; pwdata = wd; penable = 1'b0;
        psel = !which; psel0 = which;
        @(posedge clk); #1;
        penable = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            rdy = which ? pready0 : pready;
            if (rdy) break;
            n++;
            if (n > 40) break;
            @(posedge clk); #1;
        end
        got = sb_q.pop_front();
        if (!rdy) begin
            check("pready_timeout", 32'h0, 32'h1);
        end else begin
            check("wait_states", n, got.waits);
            check("pslverr", which ? pslverr0 : pslverr, got.err);
            check("prdata", which ? prdata0 : prdata, got.rdata);
        end
        if (exp_err == 1'b0 && wr && addr[11:2] < 10'd8 && !which) exp_regs[addr[4:2]] = wd;
        if (!which) exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic bus_idle();
        @(posedge clk); #1;
        psel = 1'b0; psel0 = 1'b0; penable = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        @(negedge clk);
        for (int k = 0; k < 8; k++) check(tag, regs_w[32*k +: 32], exp_regs[k]);
    endtask

    initial begin
        bit seen;
        rst = 1'b1; psel = 1'b0; psel0 = 1'b0; penable = 1'b0;
        paddr = '0; pwdata = '0; pwrite = 1'b0;
        exp_cnt = '0;
        for (int k = 0; k < 8; k++) exp_regs[k] = '0;
        repeat (2) @(negedge clk);
        check("rst_pready", pready, 1'b0);
        check("rst_pslverr", pslverr, 1'b0);
        check("rst_prdata", prdata, 32'h0);
        check("rst_regs_lo", regs_w[127:0] | regs_w0[127:0], 32'h0);
        rst = 1'b0;

        xfer(0, 12'h004, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 2);
        xfer(0, 12'h004, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF, 2);
        check("reg1_flat", regs_w[63:32], 32'hDEAD_BEEF);
        xfer(0, 12'h020, 1'b0, 32'h0, 1'b0, exp_cnt, 2);
        xfer(0, 12'h020, 1'b0, 32'h0, 1'b0, exp_cnt, 2);
        xfer(0, 12'h020, 1'b1, 32'h55, 1'b1, 32'h0, 2);
        xfer(0, 12'h020, 1'b0, 32'h0, 1'b0, exp_cnt, 2);
        xfer(0, 12'h100, 1'b1, 32'h1111_1111, 1'b1, 32'h0, 2);
        xfer(0, 12'h006, 1'b1, 32'h2222_2222, 1'b1, 32'h0, 2);
        xfer(0, 12'h100, 1'b0, 32'h0, 1'b1, 32'h0, 2);
        xfer(0, 12'h006, 1'b0, 32'h0, 1'b1, 32'h0, 2);
        bus_idle();
        check_regs("regs_after_err");

        // Abort: one access cycle of a write to reg 2, then psel drops.
        @(posedge clk); #1;
        paddr = 12'h008; pwrite = 1'b1; pwdata = 32'hABCD_0002; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check("abort_pready", pready, 1'b0);
        bus_idle();
        xfer(0, 12'h008, 1'b0, 32'h0, 1'b0, 32'h0, 2);
        xfer(0, 12'h020, 1'b0, 32'h0, 1'b0, exp_cnt, 2);
        bus_idle();

        // Zero-wait instance: back-to-back writes of the word index.
        for (int k = 0; k < 8; k++) xfer(1, 12'(k * 4), 1'b1, 32'(k), 1'b0, 32'h0, 0);
        xfer(1, 12'h014, 1'b0, 32'h0, 1'b0, 32'd5, 0);
        bus_idle();
        @(negedge clk);
        for (int k = 0; k < 8; k++) check("regs0", regs_w0[32*k +: 32], 32'(k));

        // Reset in the access phase of a write to reg 3, while pready is high.
        @(posedge clk); #1;
        paddr = 12'h00C; pwrite = 1'b1; pwdata = 32'h3333_3333; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            seen = pready;
        end
        check("pre_rst_pready", pready, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("rst_async_pready", pready, 1'b0);
        check("rst_async_pslverr", pslverr, 1'b0);
        bus_idle();
        rst = 1'b0;
        exp_cnt = '0;
        for (int k = 0; k < 8; k++) exp_regs[k] = '0;
        check_regs("regs_after_rst");
        xfer(0, 12'h020, 1'b0, 32'h0, 1'b0, 32'h0, 2);
        xfer(0, 12'h00C, 1'b0, 32'h0, 1'b0, 32'h0, 2);
        bus_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
